ex_mem: RTL and testbench
=========================

EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 Parameter BUBBLE_CNT_W, default 32, width of the saturating bubble counter.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall  input  6  pipeline stall vector; bit 3 = EX stalled, bit 4 = MEM stalled; other bits ignored.
REQ-005 flush  input  1  exception/branch flush; kills the instruction entering MEM.
REQ-006 ex_wd  input  5  EX destination register address.
REQ-007 ex_wreg  input  1  EX register-write enable.
REQ-008 ex_wdata  input  32  EX result data.
REQ-009 ex_whilo  input  1  EX HI/LO write enable.
REQ-010 ex_hi, ex_lo  input  32 each  EX HI/LO write values.
REQ-011 hilo_i  input  64  EX multi-cycle partial result (madd/msub first-cycle product).
REQ-012 cnt_i  input  2  EX multi-cycle step count.
REQ-013 mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo  output  5/1/32/1/32/32  registered copies of the EX fields, presented to MEM.
REQ-014 hilo_o  output  64  registered partial result fed back to EX.
REQ-015 cnt_o  output  2  registered step count fed back to EX.
REQ-016 bubble_cnt  output  BUBBLE_CNT_W  count of bubbles inserted since reset.

Function
REQ-017 All outputs SHALL be registered; update only on the rising clk edge; latency EX->MEM exactly 1 cycle.
REQ-018 Update priority SHALL be: rst > flush > bubble > hold > pass.
REQ-019 Flush (flush=1): all mem_* outputs, hilo_o and cnt_o SHALL become 0; bubble_cnt unchanged.
REQ-020 Bubble (stall[3]=1, stall[4]=0): mem_* outputs SHALL become 0; hilo_o<=hilo_i, cnt_o<=cnt_i; bubble_cnt increments by 1.
REQ-021 Hold (stall[3]=1, stall[4]=1): every output SHALL keep its value, including bubble_cnt.
REQ-022 Pass (stall[3]=0): mem_* <= corresponding ex_* inputs; hilo_o and cnt_o SHALL become 0 (multi-cycle op complete or not started).
REQ-023 stall[3]=0 with stall[4]=1 is illegal upstream; the block SHALL treat it as Pass.
REQ-024 bubble_cnt SHALL saturate at all-ones and never wrap.
REQ-025 Flush coincident with any stall value SHALL take the flush action.
REQ-026 A zero-valued mem_wreg/mem_whilo SHALL be the only bubble indication; no separate valid bit.
REQ-027 Field values SHALL be transferred bit-exact; no sign/zero extension or width change.

Reset
REQ-028 On rst=1 at a clk edge all outputs, including bubble_cnt, SHALL become 0 regardless of stall/flush.
REQ-029 Reset asserted during a multi-cycle op SHALL clear hilo_o/cnt_o so EX restarts from step 0.

Structure
REQ-030 Stall-bit indices (EX=3, MEM=4), register-address width, data width and zero-word constant SHALL come from the shared defines package.
REQ-031 The bubble counter SHALL be a sub-module sat_counter (parameter width, inc, clear, hold).
REQ-032 No combinational path from any input to any output.

Verification
REQ-033 Pass: ex_wd=5, ex_wreg=1, ex_wdata=0x1234_5678, stall=0 -> next cycle mem_wd=5, mem_wreg=1, mem_wdata=0x1234_5678, cnt_o=0.
REQ-034 Bubble: stall=6'b001000, ex_wreg=1, hilo_i=0x0000_0001_FFFF_FFFE, cnt_i=1 -> mem_wreg=0, mem_wdata=0, hilo_o=0x0000_0001_FFFF_FFFE, cnt_o=1, bubble_cnt+1.
REQ-035 Hold: load 0xAAAA_5555 via Pass, then stall=6'b011000 for 3 cycles with ex_wdata=0xFFFF_FFFF -> mem_wdata stays 0xAAAA_5555, bubble_cnt unchanged.
REQ-036 Flush priority: flush=1 with stall=6'b001000 and cnt_i=1 -> all mem_* 0, cnt_o=0, bubble_cnt unchanged.
REQ-037 Saturation: BUBBLE_CNT_W=4, 20 bubble cycles -> bubble_cnt=15 thereafter.
REQ-038 Reset mid-op: cnt_o=1, hilo_o nonzero, rst=1 for 1 cycle -> every output 0 next cycle.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared defines for the EX/MEM pipeline register.
//   Stall-vector bit positions, register-address/data widths, the zero
//   word, the MEM-side field bundle, and the per-cycle update decode.
package ex_mem_pkg;

  localparam int STALL_W    = 6;
  localparam int STALL_EX   = 3;
  localparam int STALL_MEM  = 4;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int HILO_W     = 2 * DATA_W;
  localparam int CNT_W      = 2;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  // Fields handed from EX to MEM.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [DATA_W-1:0]     wdata;
    logic                  whilo;
    logic [DATA_W-1:0]     hi;
    logic [DATA_W-1:0]     lo;
  } mem_fields_t;

  // A bubble is an all-zero bundle; wreg/whilo = 0 is what makes it inert.
  localparam mem_fields_t MEM_BUBBLE = '{
    wd: '0, wreg: 1'b0, wdata: ZERO_WORD, whilo: 1'b0, hi: ZERO_WORD, lo: ZERO_WORD
  };

  typedef enum logic [2:0] {
    UPD_RESET,
    UPD_FLUSH,
    UPD_BUBBLE,
    UPD_HOLD,
    UPD_PASS
  } upd_e;

  // rst > flush > bubble > hold > pass. EX running with MEM stalled cannot
  // happen upstream; it falls through to pass.
  function automatic upd_e decode_upd(input logic rst, input logic flush,
                                      input logic ex_stall, input logic mem_stall);
    if (rst)                        return UPD_RESET;
    else if (flush)                 return UPD_FLUSH;
    else if (ex_stall && !mem_stall) return UPD_BUBBLE;
    else if (ex_stall)              return UPD_HOLD;
    else                            return UPD_PASS;
  endfunction

endpackage

// File: rtl/ex_mem_if.sv
// ex_mem_if: EX<->MEM pipeline-register bus.
//   master: EX side (drives ex_*, stall, flush, hilo_i, cnt_i; sees results)
//   slave : the ex_mem register itself
interface ex_mem_if
  import ex_mem_pkg::*;
#(
  parameter int BUBBLE_CNT_W = 32
) ();

  logic [STALL_W-1:0]    stall;
  logic                  flush;
  logic [REG_ADDR_W-1:0] ex_wd;
  logic                  ex_wreg;
  logic [DATA_W-1:0]     ex_wdata;
  logic                  ex_whilo;
  logic [DATA_W-1:0]     ex_hi;
  logic [DATA_W-1:0]     ex_lo;
  logic [HILO_W-1:0]     hilo_i;
  logic [CNT_W-1:0]      cnt_i;

  logic [REG_ADDR_W-1:0] mem_wd;
  logic                  mem_wreg;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_whilo;
  logic [DATA_W-1:0]     mem_hi;
  logic [DATA_W-1:0]     mem_lo;
  logic [HILO_W-1:0]     hilo_o;
  logic [CNT_W-1:0]      cnt_o;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt;

  modport master (
    output stall, flush, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
           hilo_i, cnt_i,
    input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
           hilo_o, cnt_o, bubble_cnt
  );

  modport slave (
    input  stall, flush, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
           hilo_i, cnt_i,
    output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
           hilo_o, cnt_o, bubble_cnt
  );

endinterface

// File: rtl/ex_mem_sat_counter.sv
// sat_counter: synchronous saturating up-counter.
//   clk   : clock
//   clear : synchronous clear (highest priority)
//   hold  : freeze the count
//   inc   : add one, sticking at all-ones
//   count : registered count
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  input  logic             hold,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear)                 count_d = '0;
    else if (hold)             count_d = count_q;
    else if (inc && !(&count_q)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) count_q <= count_d;

  assign count = count_q;

endmodule

// File: rtl/ex_mem.sv
// ex_mem: EX->MEM pipeline register with bubble insertion, hold, flush and
// multi-cycle (madd/msub) partial-result feedback to EX.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ex_mem_if.slave -- EX fields in, registered MEM fields out,
//              hilo_o/cnt_o feedback, saturating bubble_cnt
// Every output is a flop; nothing combinational reaches the bus outputs.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int BUBBLE_CNT_W = 32
) (
  input  logic clk,
  input  logic rst,
  ex_mem_if.slave bus
);

  upd_e              upd;
  mem_fields_t       ex_f;
  mem_fields_t       mem_d, mem_q;
  logic [HILO_W-1:0] hilo_d, hilo_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_w;

  // Only the EX and MEM stall bits matter here.
  logic unused_stall;
  assign unused_stall = ^{bus.stall[STALL_W-1:STALL_MEM+1], bus.stall[STALL_EX-1:0]};

  assign upd = decode_upd(rst, bus.flush, bus.stall[STALL_EX], bus.stall[STALL_MEM]);

  assign ex_f = '{wd: bus.ex_wd, wreg: bus.ex_wreg, wdata: bus.ex_wdata,
                  whilo: bus.ex_whilo, hi: bus.ex_hi, lo: bus.ex_lo};

  always_comb begin
    mem_d  = mem_q;
    hilo_d = hilo_q;
    cnt_d  = cnt_q;
    unique case (upd)
      // Reset and flush both restart any multi-cycle op at step 0.
      UPD_RESET, UPD_FLUSH: begin
        mem_d  = MEM_BUBBLE;
        hilo_d = '0;
        cnt_d  = '0;
      end
      // EX is iterating: MEM gets a bubble, the partial result loops back.
      UPD_BUBBLE: begin
        mem_d  = MEM_BUBBLE;
        hilo_d = bus.hilo_i;
        cnt_d  = bus.cnt_i;
      end
      UPD_HOLD: ;
      // Instruction leaves EX: any multi-cycle op is finished.
      default: begin
        mem_d  = ex_f;
        hilo_d = '0;
        cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q  <= mem_d;
    hilo_q <= hilo_d;
    cnt_q  <= cnt_d;
  end

  sat_counter #(.WIDTH(BUBBLE_CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (upd == UPD_BUBBLE),
    .hold  (upd == UPD_HOLD),
    .count (bubble_cnt_w)
  );

  assign bus.mem_wd     = mem_q.wd;
  assign bus.mem_wreg   = mem_q.wreg;
  assign bus.mem_wdata  = mem_q.wdata;
  assign bus.mem_whilo  = mem_q.whilo;
  assign bus.mem_hi     = mem_q.hi;
  assign bus.mem_lo     = mem_q.lo;
  assign bus.hilo_o     = hilo_q;
  assign bus.cnt_o      = cnt_q;
  assign bus.bubble_cnt = bubble_cnt_w;

endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: directed + random checks of ex_mem against a behavioural model.
// Two instances share the stimulus: default 32-bit bubble counter and a
// 4-bit one for saturation.
`timescale 1ns/1ps
module tb_ex_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi, ex_lo;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;

  always #5 clk = ~clk;

  ex_mem_if #(.BUBBLE_CNT_W(32)) bus  ();
  ex_mem_if #(.BUBBLE_CNT_W(4))  bus4 ();

  assign bus.stall = stall;      assign bus4.stall = stall;
  assign bus.flush = flush;      assign bus4.flush = flush;
  assign bus.ex_wd = ex_wd;      assign bus4.ex_wd = ex_wd;
  assign bus.ex_wreg = ex_wreg;  assign bus4.ex_wreg = ex_wreg;
  assign bus.ex_wdata = ex_wdata; assign bus4.ex_wdata = ex_wdata;
  assign bus.ex_whilo = ex_whilo; assign bus4.ex_whilo = ex_whilo;
  assign bus.ex_hi = ex_hi;      assign bus4.ex_hi = ex_hi;
  assign bus.ex_lo = ex_lo;      assign bus4.ex_lo = ex_lo;
  assign bus.hilo_i = hilo_i;    assign bus4.hilo_i = hilo_i;
  assign bus.cnt_i = cnt_i;      assign bus4.cnt_i = cnt_i;

  ex_mem #(.BUBBLE_CNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus));
  ex_mem #(.BUBBLE_CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int total = 0;
  int bad   = 0;

  // Reference model: expected register contents after each edge.
  logic [4:0]  m_wd;
  logic        m_wreg, m_whilo;
  logic [31:0] m_wdata, m_hi, m_lo;
  logic [63:0] m_hilo;
  logic [1:0]  m_cnt;
  longint unsigned m_bc;
  int unsigned     m_bc4;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit ex_st, mem_st;
    ex_st  = stall[3];
    mem_st = stall[4];
    if (rst) begin
      {m_wd, m_wreg, m_wdata, m_whilo, m_hi, m_lo} = '0;
      m_hilo = 0; m_cnt = 0; m_bc = 0; m_bc4 = 0;
    end else if (flush) begin
      {m_wd, m_wreg, m_wdata, m_whilo, m_hi, m_lo} = '0;
      m_hilo = 0; m_cnt = 0;
    end else if (ex_st && !mem_st) begin
      {m_wd, m_wreg, m_wdata, m_whilo, m_hi, m_lo} = '0;
      m_hilo = hilo_i; m_cnt = cnt_i;
      if (m_bc < 64'hFFFF_FFFF) m_bc++;
      if (m_bc4 < 15) m_bc4++;
    end else if (ex_st && mem_st) begin
      // everything holds
    end else begin
      m_wd = ex_wd; m_wreg = ex_wreg; m_wdata = ex_wdata;
      m_whilo = ex_whilo; m_hi = ex_hi; m_lo = ex_lo;
      m_hilo = 0; m_cnt = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".mem_wd"},    64'(bus.mem_wd),     64'(m_wd));
    chk({tag, ".mem_wreg"},  64'(bus.mem_wreg),   64'(m_wreg));
    chk({tag, ".mem_wdata"}, 64'(bus.mem_wdata),  64'(m_wdata));
    chk({tag, ".mem_whilo"}, 64'(bus.mem_whilo),  64'(m_whilo));
    chk({tag, ".mem_hi"},    64'(bus.mem_hi),     64'(m_hi));
    chk({tag, ".mem_lo"},    64'(bus.mem_lo),     64'(m_lo));
    chk({tag, ".hilo_o"},    bus.hilo_o,          m_hilo);
    chk({tag, ".cnt_o"},     64'(bus.cnt_o),      64'(m_cnt));
    chk({tag, ".bubble_cnt"},  64'(bus.bubble_cnt),  m_bc);
    chk({tag, ".bubble_cnt4"}, 64'(bus4.bubble_cnt), 64'(m_bc4));
    chk({tag, ".w4_mem_wdata"}, 64'(bus4.mem_wdata), 64'(m_wdata));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    #1;
    check_all(tag);
  endtask

  task automatic rand_ex();
    ex_wd    = 5'($urandom);
    ex_wreg  = 1'($urandom);
    ex_wdata = $urandom;
    ex_whilo = 1'($urandom);
    ex_hi    = $urandom;
    ex_lo    = $urandom;
    hilo_i   = {$urandom, $urandom};
    cnt_i    = 2'($urandom);
  endtask

  initial begin
    rst = 1'b1; stall = 6'b011000; flush = 1'b1;
    rand_ex();
    m_bc = 0; m_bc4 = 0;
    step("reset");
    chk("reset.cnt_o_zero", 64'(bus.cnt_o), 64'd0);

    // Pass
    rst = 1'b0; flush = 1'b0; stall = '0;
    rand_ex(); ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678;
    step("pass");
    chk("pass.wdata_lit", 64'(bus.mem_wdata), 64'h1234_5678);
    chk("pass.wd_lit",    64'(bus.mem_wd),    64'd5);

    // Bubble
    rand_ex(); stall = 6'b001000; ex_wreg = 1'b1;
    hilo_i = 64'h0000_0001_FFFF_FFFE; cnt_i = 2'd1;
    step("bubble");
    chk("bubble.hilo_lit", bus.hilo_o, 64'h0000_0001_FFFF_FFFE);
    chk("bubble.cnt_lit",  64'(bus.bubble_cnt), 64'd1);

    // Hold
    rand_ex(); stall = '0; ex_wdata = 32'hAAAA_5555;
    step("hold_load");
    stall = 6'b011000; ex_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) step("hold");
    chk("hold.wdata_lit", 64'(bus.mem_wdata), 64'hAAAA_5555);

    // Flush beats bubble
    rand_ex(); flush = 1'b1; stall = 6'b001000; cnt_i = 2'd1;
    step("flush");
    chk("flush.cnt_lit", 64'(bus.cnt_o), 64'd0);
    flush = 1'b0;

    // Saturation of the 4-bit counter
    stall = 6'b001000;
    for (int i = 0; i < 20; i++) begin rand_ex(); step("sat"); end
    chk("sat.bc4_15", 64'(bus4.bubble_cnt), 64'd15);
    rand_ex(); step("sat_after");
    chk("sat.bc4_stay", 64'(bus4.bubble_cnt), 64'd15);

    // Reset mid multi-cycle op
    rand_ex(); stall = 6'b001000; cnt_i = 2'd1; hilo_i = 64'hDEAD_BEEF_0000_0001;
    step("midop");
    rst = 1'b1; rand_ex();
    step("midop_rst");
    chk("midop_rst.hilo_zero", bus.hilo_o, 64'd0);
    rst = 1'b0;

    // Illegal stall[3]=0, stall[4]=1 acts as pass
    rand_ex(); stall = 6'b010000;
    step("illegal_pass");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_ex();
      stall = 6'($urandom);
      flush = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 49) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
